// File: rtl/instr_pack.sv
// Shared types for the ALU control path: the ALU operation encoding,
// the dispatcher FSM states and the buffered request payload.
package instr_pack;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        add = 3'd0,
        sub = 3'd1,
        amp = 3'd2,
        lor = 3'd3,
        eor = 3'd4
    } math;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } dispatch_state;

    typedef struct packed {
        math               op;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic              rs;
    } req_t;

endpackage

// File: rtl/alu_dispatch_if.sv
// Bundle of the request stream, the ALU control/operand bus and the result
// stream. The dispatcher uses the slave view; its environment the master view.
interface alu_dispatch_if;

    logic                           req_valid;
    logic                           req_ready;
    instr_pack::math                req_op;
    logic [instr_pack::DATA_W-1:0]  req_x;
    logic [instr_pack::DATA_W-1:0]  req_y;
    logic                           req_rs;

    logic [instr_pack::DATA_W-1:0]  alu_x;
    logic [instr_pack::DATA_W-1:0]  alu_y;
    instr_pack::math                alu_op;
    logic                           alu_en;
    logic                           alu_rs;
    logic [instr_pack::DATA_W-1:0]  alu_r;
    logic [instr_pack::DATA_W-1:0]  alu_s;

    logic                           res_valid;
    logic                           res_ready;
    logic [instr_pack::DATA_W-1:0]  res_data;
    logic                           res_rs;
    logic                           res_zero;

    modport master (
        output req_valid, req_op, req_x, req_y, req_rs, res_ready, alu_r, alu_s,
        input  req_ready, alu_x, alu_y, alu_op, alu_en, alu_rs,
               res_valid, res_data, res_rs, res_zero
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, req_rs, res_ready, alu_r, alu_s,
        output req_ready, alu_x, alu_y, alu_op, alu_en, alu_rs,
               res_valid, res_data, res_rs, res_zero
    );

endinterface

// File: rtl/alu_dispatch_req_fifo.sv
// Small circular request buffer. Pointers wrap naturally because DEPTH is a
// power of two; the count carries one extra bit so full and empty differ.
module req_fifo
    import instr_pack::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t head,
    output logic empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // Payload storage; written on push only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_dispatch.sv
// Dispatcher between the instruction decoder and the latch-based ALU.
// Operands are registered and only change when a new request is issued, so
// the ALU's level-sensitive enable sees a clean one-cycle pulse and its
// latched outputs stay quiet while the result is captured and held.
module alu_dispatch
    import instr_pack::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    alu_dispatch_if.slave bus
);

    dispatch_state     state;
    dispatch_state     next_state;
    logic              load;
    logic              push;
    logic              empty;
    logic              full;
    req_t              head;
    req_t              req_in;

    math               op_q;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] y_q;
    logic              rs_q;

    logic [DATA_W-1:0] sel_val;
    logic [DATA_W-1:0] res_data_q;
    logic              res_rs_q;
    logic              res_zero_q;

    assign push      = bus.req_valid && !full;
    assign req_in.op = bus.req_op;
    assign req_in.x  = bus.req_x;
    assign req_in.y  = bus.req_y;
    assign req_in.rs = bus.req_rs;

    req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (req_in),
        .pop       (load),
        .head      (head),
        .empty     (empty),
        .full      (full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state; a pop and operand load happen on every entry into ISSUE.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    load       = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = CAPTURE;
            CAPTURE: next_state = HOLD;
            HOLD: begin
                if (bus.res_ready) begin
                    if (!empty) begin
                        load       = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand registers feeding the ALU; updated only on issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= add;
            x_q  <= '0;
            y_q  <= '0;
            rs_q <= 1'b0;
        end else if (load) begin
            op_q <= head.op;
            x_q  <= head.x;
            y_q  <= head.y;
            rs_q <= head.rs;
        end
    end

    assign sel_val = rs_q ? bus.alu_s : bus.alu_r;

    // Result capture one cycle after the enable pulse, once the ALU latch has settled.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_data_q <= '0;
            res_rs_q   <= 1'b0;
            res_zero_q <= 1'b0;
        end else if (state == CAPTURE) begin
            res_data_q <= sel_val;
            res_rs_q   <= rs_q;
            res_zero_q <= (sel_val == '0);
        end
    end

    assign bus.req_ready = !full;
    assign bus.alu_x     = x_q;
    assign bus.alu_y     = y_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_rs    = rs_q;
    assign bus.alu_en    = (state == ISSUE);
    assign bus.res_valid = (state == HOLD);
    assign bus.res_data  = res_data_q;
    assign bus.res_rs    = res_rs_q;
    assign bus.res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: an ALU stand-in, a queue-based
// reference of expected results, and directed plus randomized stimulus.
`timescale 1ns/1ps
module tb_alu_dispatch;
    import instr_pack::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_dispatch_if bus ();

    alu_dispatch #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       rs;
    } exp_t;

    typedef struct packed {
        math        op;
        logic [7:0] x;
        logic [7:0] y;
        logic       rs;
    } iss_t;

    exp_t       exp_q [$];
    iss_t       iss_q [$];
    logic [7:0] res_log [$];

    int checks;
    int errors;
    int cyc;
    int took;
    int last_en;
    int en_cnt;
    int en0;
    logic period_mode;
    logic rand_ready;

    logic        prev_ok;
    logic        prev_en;
    logic [19:0] prev_ops;
    logic        prev_rv;
    logic        prev_rr;
    logic [9:0]  prev_res;

    function automatic logic [7:0] alu_f(math op, logic [7:0] a, logic [7:0] b);
        case (op)
            add:     return a + b;
            sub:     return a - b;
            amp:     return a & b;
            lor:     return a | b;
            eor:     return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    // ALU stand-in: holds its outputs between enables; the unselected output
    // carries the complement so a wrong select is always visible.
    logic [7:0] alu_r_m;
    logic [7:0] alu_s_m;
    assign bus.alu_r = alu_r_m;
    assign bus.alu_s = alu_s_m;
    always @(posedge clk) begin
        if (bus.alu_en) begin
            if (bus.alu_rs) begin
                alu_s_m <= alu_f(bus.alu_op, bus.alu_x, bus.alu_y);
                alu_r_m <= ~alu_f(bus.alu_op, bus.alu_x, bus.alu_y);
            end else begin
                alu_r_m <= alu_f(bus.alu_op, bus.alu_x, bus.alu_y);
                alu_s_m <= ~alu_f(bus.alu_op, bus.alu_x, bus.alu_y);
            end
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        iss_t s;
        took = 0;
        if (reset) begin
            exp_q.delete();
            iss_q.delete();
            prev_ok = 1'b0;
            last_en = -1;
            return;
        end
        if (bus.req_valid && bus.req_ready) begin
            took   = 1;
            e.data = alu_f(bus.req_op, bus.req_x, bus.req_y);
            e.rs   = bus.req_rs;
            exp_q.push_back(e);
            s.op = bus.req_op;
            s.x  = bus.req_x;
            s.y  = bus.req_y;
            s.rs = bus.req_rs;
            iss_q.push_back(s);
        end
        if (bus.alu_en) begin
            en_cnt++;
            chk("en_pending", 32'(iss_q.size() != 0), 1);
            if (iss_q.size() != 0) begin
                s = iss_q.pop_front();
                chk("alu_ops", {bus.alu_op, bus.alu_x, bus.alu_y, bus.alu_rs}, s);
            end
            if (prev_ok) chk("en_once", prev_en, 0);
            if (period_mode && last_en >= 0) chk("en_period", cyc - last_en, 3);
            last_en = cyc;
        end else if (prev_ok) begin
            chk("op_hold", {bus.alu_op, bus.alu_x, bus.alu_y, bus.alu_rs}, prev_ops);
        end
        if (bus.res_valid && bus.res_ready) begin
            chk("res_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_data", bus.res_data, e.data);
                chk("res_rs", bus.res_rs, e.rs);
                chk("res_zero", bus.res_zero, 32'(e.data == 8'h00));
                res_log.push_back(bus.res_data);
            end
        end
        if (prev_ok && prev_rv && !prev_rr) begin
            chk("res_kept", bus.res_valid, 1);
            chk("res_hold", {bus.res_data, bus.res_rs, bus.res_zero}, prev_res);
        end
        prev_en  = bus.alu_en;
        prev_ops = {bus.alu_op, bus.alu_x, bus.alu_y, bus.alu_rs};
        prev_rv  = bus.res_valid;
        prev_rr  = bus.res_ready;
        prev_res = {bus.res_data, bus.res_rs, bus.res_zero};
        prev_ok  = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_ready) bus.res_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send(math op, logic [7:0] x, logic [7:0] y, logic rs);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_x     = x;
        bus.req_y     = y;
        bus.req_rs    = rs;
        do begin
            step();
            n++;
        end while (took == 0 && n < 200);
        chk("send_accept", took, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.res_valid) && n < 300) begin
            step();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; took = 0; last_en = -1; en_cnt = 0; en0 = 0;
        period_mode = 1'b0; rand_ready = 1'b0; prev_ok = 1'b0;
        prev_en = 1'b0; prev_ops = '0; prev_rv = 1'b0; prev_rr = 1'b0; prev_res = '0;
        reset = 1'b1;
        bus.res_ready = 1'b1;
        // A request offered while reset is held must be dropped.
        bus.req_valid = 1'b1; bus.req_op = add; bus.req_x = 8'h77; bus.req_y = 8'h01; bus.req_rs = 1'b0;
        repeat (3) step();
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_alu_en", bus.alu_en, 0);
        chk("rst_alu_x", bus.alu_x, 0);
        chk("rst_res_data", {bus.res_data, bus.res_rs, bus.res_zero}, 0);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        repeat (4) step();
        chk("rst_dropped", en_cnt, 0);

        // Single add: enable at N+1, result at N+3.
        bus.req_valid = 1'b1; bus.req_op = add; bus.req_x = 8'h12; bus.req_y = 8'h34; bus.req_rs = 1'b0;
        step();
        chk("t1_took", took, 1);
        bus.req_valid = 1'b0;
        chk("t1_en_n", bus.alu_en, 0);
        step();
        chk("t1_en_n1", bus.alu_en, 1);
        step();
        chk("t1_en_n2", bus.alu_en, 0);
        chk("t1_rv_n2", bus.res_valid, 0);
        step();
        chk("t1_rv_n3", bus.res_valid, 1);
        chk("t1_data", bus.res_data, 8'h46);
        chk("t1_rs", bus.res_rs, 0);
        chk("t1_zero", bus.res_zero, 0);
        drain();

        // Zero result through the s output while r shows 8'hFF.
        send(sub, 8'h05, 8'h05, 1'b1);
        drain();
        chk("t2_data", res_log[$], 8'h00);
        chk("t2_zero_flag", bus.res_zero, 1);

        // Consumer stall: FIFO fills, results held, then released in order.
        res_log.delete();
        bus.res_ready = 1'b0;
        send(eor, 8'hF0, 8'h0F, 1'b0);
        send(amp, 8'hF0, 8'h3C, 1'b1);
        chk("t3_pushpop_ready", bus.req_ready, 1);
        send(lor, 8'hF0, 8'h0C, 1'b0);
        chk("t3_full", bus.req_ready, 0);
        bus.req_valid = 1'b1; bus.req_op = add; bus.req_x = 8'h01; bus.req_y = 8'h01; bus.req_rs = 1'b1;
        repeat (6) begin
            step();
            chk("t3_no_push", took, 0);
        end
        bus.res_ready = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (took == 0 && n < 50);
        chk("t3_4th_accept", took, 1);
        bus.req_valid = 1'b0;
        drain();
        chk("t3_count", res_log.size(), 4);
        if (res_log.size() == 4) begin
            chk("t3_r0", res_log[0], 8'hFF);
            chk("t3_r1", res_log[1], 8'h30);
            chk("t3_r2", res_log[2], 8'hFC);
            chk("t3_r3", res_log[3], 8'h02);
        end

        // Back-to-back random stream with the consumer always ready.
        period_mode = 1'b1;
        last_en = -1;
        en0 = en_cnt;
        for (int i = 0; i < 20; i++) begin
            send(math'($urandom_range(0, 4)), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        drain();
        period_mode = 1'b0;
        chk("t4_en_cnt", en_cnt - en0, 20);

        // Random consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(math'($urandom_range(0, 4)), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        bus.res_ready = 1'b1;
        drain();

        // Reset while a result is being captured and another request waits.
        send(add, 8'h10, 8'h20, 1'b0);
        send(eor, 8'hAA, 8'h55, 1'b1);
        n = 0;
        while (!bus.alu_en && n < 20) begin
            step();
            n++;
        end
        chk("t6_en_seen", bus.alu_en, 1);
        step();
        reset = 1'b1;
        step();
        chk("t6_rv", bus.res_valid, 0);
        chk("t6_en", bus.alu_en, 0);
        chk("t6_ready", bus.req_ready, 1);
        reset = 1'b0;
        en0 = en_cnt;
        repeat (5) step();
        chk("t6_fifo_empty", en_cnt - en0, 0);
        send(sub, 8'h30, 8'h10, 1'b1);
        drain();
        chk("t6_post", res_log[$], 8'h20);

        chk("final_empty", exp_q.size() + iss_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
